// File: rtl/alu_pkg.sv
// Shared opcodes, operand width and the queued command record for the ALU issue stage.
// Latency: none, declarations only.
// Backpressure: not applicable.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       f;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic command FIFO: storage, wrap-around pointers and occupancy count.
// Latency: a push is visible on head after the writing edge.
// Backpressure: a full FIFO refuses push even when a pop happens in the same cycle.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_cmd_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_dat,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = empty ? T'('0) : mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Command queue plus result register around the combinational ALU; optional ALU_DIV_ZERO_GUARD_EN.
// Latency: command pushed at edge N into an idle stage is valid after edge N+1; 1 result/cycle.
// Backpressure: in_ready depends only on queue occupancy; result holds while out_ready is low.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_f,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_f,
    input  logic [W-1:0] alu_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic [2:0]   out_f,
    output logic         out_err
);

    alu_cmd_t     push_cmd;
    alu_cmd_t     head;
    logic         full;
    logic         empty;
    logic         cap;
    logic [W-1:0] y_next;

    assign push_cmd = '{a: in_a, b: in_b, f: in_f};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (alu_cmd_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (in_valid),
        .push_dat (push_cmd),
        .pop      (cap),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    assign in_ready = ~full;
    assign alu_a    = head.a;
    assign alu_b    = head.b;
    assign alu_f    = head.f;
    assign cap      = ~empty & (~out_valid | out_ready);

`ifdef ALU_DIV_ZERO_GUARD_EN
    logic div0;

    assign div0   = (head.f == OP_DIV) && (head.b == '0);
    assign y_next = div0 ? '1 : alu_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (cap) begin
            out_err <= div0;
        end
    end
`else
    assign y_next  = alu_y;
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_f     <= '0;
        end else if (cap) begin
            out_valid <= 1'b1;
            out_y     <= y_next;
            out_f     <= head.f;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU closing the alu_* loop.
// Vector table for single commands, hand-written sequences for fill, release, wrap, guard and reset.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_f;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [2:0]  out_f;
    logic        out_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(4), .W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_f      (in_f),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_f     (out_f),
        .out_err   (out_err)
    );

    // Divide by zero returns a marker value standing in for the ALU's undefined result.
    always_comb begin
        alu_y = '0;
        case (alu_f)
            3'b000: alu_y = alu_a & alu_b;
            3'b001: alu_y = alu_a | alu_b;
            3'b010: alu_y = ~(alu_a & alu_b);
            3'b011: alu_y = ~(alu_a | alu_b);
            3'b100: alu_y = alu_a + alu_b;
            3'b101: alu_y = alu_a - alu_b;
            3'b110: alu_y = alu_a * alu_b;
            3'b111: alu_y = (alu_b == '0) ? 32'hDEAD_BEEF : alu_a / alu_b;
            default: alu_y = '0;
        endcase
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_f     = f;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_f     = '0;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  ef;

        vt[0]  = '{32'd5,          32'd3,          3'b100, 32'd8};
        vt[1]  = '{32'hF0F0_1234,  32'h0FF0_FF00,  3'b000, 32'h00F0_1200};
        vt[2]  = '{32'hF000_000F,  32'h0000_F0F0,  3'b001, 32'hF000_F0FF};
        vt[3]  = '{32'hF0F0_0000,  32'hFF00_0000,  3'b010, 32'h0FFF_FFFF};
        vt[4]  = '{32'h0000_00FF,  32'h0000_FF00,  3'b011, 32'hFFFF_0000};
        vt[5]  = '{32'hFFFF_FFFF,  32'd2,          3'b100, 32'd1};
        vt[6]  = '{32'd10,         32'd4,          3'b101, 32'd6};
        vt[7]  = '{32'd3,          32'd5,          3'b101, 32'hFFFF_FFFE};
        vt[8]  = '{32'd3,          32'd7,          3'b110, 32'd21};
        vt[9]  = '{32'h0001_0000,  32'h0001_0000,  3'b110, 32'd0};
        vt[10] = '{32'h0001_0000,  32'h0001_0001,  3'b110, 32'h0001_0000};
        vt[11] = '{32'd100,        32'd7,          3'b111, 32'd14};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_in();
        #1;
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_y",     out_y,          32'd0);
        check("rst out_f",     32'(out_f),     32'd0);
        check("rst out_err",   32'(out_err),   32'd0);
        check("rst alu_f",     32'(alu_f),     32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single commands, one at a time with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].a, vt[i].b, vt[i].f);
            tick();
            idle_in();
            check($sformatf("vec%0d not yet valid", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d head a", i), alu_a, vt[i].a);
            check($sformatf("vec%0d head f", i), 32'(alu_f), 32'(vt[i].f));
            tick();
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d out_y", i), out_y, vt[i].y);
            check($sformatf("vec%0d out_f", i), 32'(out_f), 32'(vt[i].f));
            check($sformatf("vec%0d out_err", i), 32'(out_err), 32'd0);
            check($sformatf("vec%0d head empty", i), alu_b, 32'd0);
        end
        tick();
        check("idle out_valid", 32'(out_valid), 32'd0);

        // Fill: four queued plus one held result.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: drive(32'd5,         32'd3,         3'b100);
                1: drive(32'd10,        32'd4,         3'b101);
                2: drive(32'd3,         32'd7,         3'b110);
                3: drive(32'hF0F0_0000, 32'hFF00_0000, 3'b010);
                default: drive(32'h0000_000F, 32'h0000_00F0, 3'b001);
            endcase
            tick();
            check($sformatf("fill%0d in_ready", k), 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
            if (k > 0) begin
                check($sformatf("fill%0d held y", k), out_y, 32'd8);
            end
        end
        drive(32'h0000_00FF, 32'h0000_000F, 3'b000);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("full%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("full%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("full%0d held y", k), out_y, 32'd8);
            check($sformatf("full%0d held f", k), 32'(out_f), 32'(3'b100));
        end

        // Release with the sixth command still offered on the popping edge.
        out_ready = 1'b1;
        tick();
        idle_in();
        check("rel0 y",        out_y,          32'd6);
        check("rel0 f",        32'(out_f),     32'(3'b101));
        check("rel0 in_ready", 32'(in_ready),  32'd1);
        tick();
        check("rel1 y",        out_y,          32'd21);
        check("rel1 f",        32'(out_f),     32'(3'b110));
        tick();
        check("rel2 y",        out_y,          32'h0FFF_FFFF);
        check("rel2 f",        32'(out_f),     32'(3'b010));
        tick();
        check("rel3 y",        out_y,          32'h0000_00FF);
        check("rel3 valid",    32'(out_valid), 32'd1);
        check("rel3 empty",    32'(alu_a),     32'd0);
        tick();
        check("rel4 drained",  32'(out_valid), 32'd0);

        // Stream ten commands across two pointer wraps.
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                ea = 32'd100 + 32'(i) * 32'd16;
                eb = 32'(i);
                ef = i[0] ? 3'b101 : 3'b100;
                drive(ea, eb, ef);
            end else begin
                idle_in();
            end
            tick();
            if (i > 0) begin
                ea = 32'd100 + 32'(i - 1) * 32'd16;
                eb = 32'(i - 1);
                ef = (i - 1) % 2 == 1 ? 3'b101 : 3'b100;
                check($sformatf("wrap%0d valid", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("wrap%0d y", i - 1), out_y, (ef == 3'b101) ? ea - eb : ea + eb);
                check($sformatf("wrap%0d f", i - 1), 32'(out_f), 32'(ef));
            end
            check($sformatf("wrap%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        idle_in();
        tick();
        check("wrap drained", 32'(out_valid), 32'd0);

        // Divide-by-zero, then a normal divide.
        drive(32'd9, 32'd0, 3'b111);
        tick();
        drive(32'd9, 32'd3, 3'b111);
        tick();
        idle_in();
`ifdef ALU_DIV_ZERO_GUARD_EN
        check("div0 y",   out_y,          32'hFFFF_FFFF);
        check("div0 err", 32'(out_err),   32'd1);
`else
        check("div0 y",   out_y,          32'hDEAD_BEEF);
        check("div0 err", 32'(out_err),   32'd0);
`endif
        check("div0 f",   32'(out_f),     32'(3'b111));
        tick();
        check("div y",    out_y,          32'd3);
        check("div err",  32'(out_err),   32'd0);
        tick();

        // Mid-stream reset: one result held, three commands queued.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(32'd20 + 32'(k), 32'd1, 3'b100);
            tick();
        end
        idle_in();
        check("pre-rst valid", 32'(out_valid), 32'd1);
        check("pre-rst y",     out_y,          32'd21);
        rst_n = 1'b0;
        #1;
        check("mid-rst in_ready",  32'(in_ready),  32'd1);
        check("mid-rst out_valid", 32'(out_valid), 32'd0);
        check("mid-rst out_y",     out_y,          32'd0);
        check("mid-rst out_f",     32'(out_f),     32'd0);
        check("mid-rst alu_a",     alu_a,          32'd0);
        tick();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("post-rst%0d valid", k), 32'(out_valid), 32'd0);
            check($sformatf("post-rst%0d alu_a", k), alu_a, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
